mtr_drv: RTL and testbench
==========================

MTR_DRV -- requirements
Module: mtr_drv

Interface
REQ-001 Parameter NONOVERLAP, default 32: dead-time in clocks inserted at every PWM polarity change (legal 1..255).
REQ-002 Parameter BLANK, default 128: count value before which OVR_I is ignored in each period.
REQ-003 Parameter OVR_LIMIT, default 4: number of consecutive faulted periods that causes shutdown (legal 1..15).
REQ-004 clk  input  1  system clock; the only clock.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 lft_spd  input  12  signed left wheel speed from the balance controller.
REQ-007 rght_spd  input  12  signed right wheel speed from the balance controller.
REQ-008 OVR_I  input  1  asynchronous overcurrent flag from the motor driver chip, shared by both bridges.
REQ-009 PWM1_lft, PWM2_lft  output  1 each  left bridge high-side / low-side gate drives.
REQ-010 PWM1_rght, PWM2_rght  output  1 each  right bridge high-side / low-side gate drives.
REQ-011 PWM_synch  output  1  one-cycle pulse at each period end, used as the A2D trigger.
REQ-012 OVR_I_shtdwn  output  1  latched overcurrent shutdown.

Function
REQ-013 An 11-bit free-running counter cnt SHALL increment every clock and wrap from 2047 to 0, giving a period of 2048 clocks.
REQ-014 Per motor, duty SHALL equal {~spd[11], spd[10:1]}: spd 0 gives 1024, spd 2047 gives 2047, spd -2048 gives 0.
REQ-015 Duty registers SHALL load only on the edge where cnt wraps from 2047 to 0; an input change mid-period has no effect until the next period.
REQ-016 Per motor, a registered pwm_sig SHALL be high on the cycle after any cycle where cnt < duty_reg.
REQ-017 Per motor, a stable counter SHALL clear to 0 on any pwm_sig change and otherwise increment, saturating at NONOVERLAP.
REQ-018 PWM1 SHALL be registered as pwm_sig AND (stable == NONOVERLAP).
REQ-019 PWM2 SHALL be registered as NOT pwm_sig AND (stable == NONOVERLAP).
REQ-020 PWM1 and PWM2 of the same bridge SHALL never be high simultaneously.
REQ-021 Boundary, duty 0: PWM1 stays low and PWM2 stays continuously high.
REQ-022 Boundary, duty 2047: PWM2 never rises, and PWM1 is low for NONOVERLAP+1 cycles per period.
REQ-023 PWM_synch SHALL be high exactly on the cycle where cnt == 2047.
REQ-024 OVR_I SHALL pass through a 2-flop synchronizer to form ovr_s before any use.
REQ-025 A period fault flag SHALL set when ovr_s is high while cnt >= BLANK.
REQ-026 The period fault flag SHALL clear at the wrap.
REQ-027 At cnt == 2047, a consecutive-fault counter SHALL increment if the flag (or the qualifying ovr_s on that cycle) is set, and SHALL clear to 0 otherwise.
REQ-028 When the consecutive-fault counter reaches OVR_LIMIT, OVR_I_shtdwn SHALL rise on the next clock and stay high until rst_n.
REQ-029 While OVR_I_shtdwn is high, all four PWM outputs SHALL be low in the same cycle.
REQ-030 While OVR_I_shtdwn is high, cnt and PWM_synch SHALL keep running.

Reset
REQ-031 On rst_n low, asynchronously: cnt = 0, both duty registers = 1024, pwm_sig = 0, stable counters = 0.
REQ-032 On rst_n low, asynchronously: fault flag = 0, consecutive-fault counter = 0, synchronizer flops = 0.
REQ-033 On rst_n low, asynchronously: all PWM outputs = 0, PWM_synch = 0, OVR_I_shtdwn = 0.
REQ-034 Reset asserted mid-period or during shutdown SHALL return all of the above to reset values; operation restarts from cnt = 0 after release.

Verification
REQ-035 Both spd 0, defaults -> from the second period on, each PWM1 and PWM2 is high 992 cycles per 2048-cycle period and never overlaps its partner.
REQ-036 lft_spd 2047 and rght_spd -2048 -> PWM2_lft never high, PWM1_lft low 33 cycles per period; PWM1_rght never high, PWM2_rght constantly high.
REQ-037 lft_spd changed from 0 to 1000 at cnt 500 -> high time is unchanged in the current period and becomes 1524-32 = 1492 cycles from the next wrap.
REQ-038 OVR_I pulsed at cnt 200..300 for 4 consecutive periods -> OVR_I_shtdwn rises 1 clock after the 4th cnt == 2047, all PWM outputs go low, and both stay that way until rst_n.
REQ-039 Fault-counter boundary checks: OVR_I only inside cnt 0..127 every period -> never shuts down; 3 faulted periods, 1 clean, then 3 faulted -> no shutdown.
REQ-040 rst_n pulsed low mid-period during shutdown -> all outputs 0 immediately; normal 50% PWM resumes from cnt 0 after release.

Source files
------------

// File: rtl/mtr_drv.sv
// Dual H-bridge PWM gate driver: 2048-clock period, dead-time on every
// polarity change, and a latched shutdown after consecutive overcurrent periods.
module mtr_drv #(
  parameter int unsigned NONOVERLAP = 32,
  parameter int unsigned BLANK      = 128,
  parameter int unsigned OVR_LIMIT  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic        OVR_I,
  output logic        PWM1_lft,
  output logic        PWM2_lft,
  output logic        PWM1_rght,
  output logic        PWM2_rght,
  output logic        PWM_synch,
  output logic        OVR_I_shtdwn
);

  localparam int unsigned CNT_W = 11;
  localparam int unsigned SPD_W = 12;
  localparam int unsigned STB_W = 8;
  localparam int unsigned FLT_W = 4;
  localparam int unsigned NMOT  = 2;

  localparam logic [CNT_W-1:0] CNT_LAST = '1;
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_LAST - CNT_W'(1);
  localparam logic [CNT_W-1:0] DUTY_RST = CNT_W'(1024);
  localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(NONOVERLAP);
  localparam logic [FLT_W-1:0] FLT_MAX  = FLT_W'(OVR_LIMIT);

  typedef enum logic {ST_RUN, ST_SHTDWN} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_synch;
  logic                       r_sync1;
  logic                       r_sync2;
  logic                       r_flt;
  logic [FLT_W-1:0]           r_flt_cnt;
  logic [FLT_W-1:0]           w_flt_cnt_nxt;
  logic                       w_wrap;
  logic                       w_ovr_q;
  logic                       w_period_flt;
  logic                       w_kill;
  logic [NMOT-1:0][SPD_W-1:0] w_spd;
  logic                       w_unused_lsb;

  assign w_spd        = {rght_spd, lft_spd};
  assign w_unused_lsb = lft_spd[0] ^ rght_spd[0];

  // Fault accounting and shutdown decision; w_kill blanks the gates on the
  // same edge the shutdown state is entered.
  always_comb begin
    w_wrap        = (r_cnt == CNT_LAST);
    w_ovr_q       = r_sync2 && (r_cnt >= BLANK_C);
    w_period_flt  = r_flt || w_ovr_q;
    w_flt_cnt_nxt = r_flt_cnt;
    w_state_nxt   = r_state;
    if (w_wrap) begin
      if (!w_period_flt) begin
        w_flt_cnt_nxt = '0;
      end else if (r_flt_cnt != FLT_MAX) begin
        w_flt_cnt_nxt = r_flt_cnt + FLT_W'(1);
      end
    end
    if (w_flt_cnt_nxt == FLT_MAX) begin
      w_state_nxt = ST_SHTDWN;
    end
    w_kill = (w_state_nxt == ST_SHTDWN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Period counter, A2D trigger, overcurrent synchronizer and period fault flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_synch   <= 1'b0;
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_flt     <= 1'b0;
      r_flt_cnt <= '0;
    end else begin
      r_cnt     <= r_cnt + CNT_W'(1);
      r_synch   <= (r_cnt == CNT_PRE);
      r_sync1   <= OVR_I;
      r_sync2   <= r_sync1;
      r_flt     <= w_wrap ? 1'b0 : w_period_flt;
      r_flt_cnt <= w_flt_cnt_nxt;
    end
  end

  for (genvar m = 0; m < NMOT; m++) begin : g_mot
    logic [CNT_W-1:0] r_duty;
    logic [CNT_W-1:0] w_duty_nxt;
    logic             w_pwm_nxt;
    logic             r_pwm_sig;
    logic [STB_W-1:0] r_stable;
    logic             r_pwm1;
    logic             r_pwm2;

    // Offset-binary duty: sign bit inverted, magnitude halved
    assign w_duty_nxt = {~w_spd[m][SPD_W-1], w_spd[m][SPD_W-2:1]};
    assign w_pwm_nxt  = (r_cnt < r_duty);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_duty    <= DUTY_RST;
        r_pwm_sig <= 1'b0;
        r_stable  <= '0;
        r_pwm1    <= 1'b0;
        r_pwm2    <= 1'b0;
      end else begin
        if (w_wrap) begin
          r_duty <= w_duty_nxt;
        end
        r_pwm_sig <= w_pwm_nxt;
        if (w_pwm_nxt != r_pwm_sig) begin
          r_stable <= '0;
        end else if (r_stable != STB_MAX) begin
          r_stable <= r_stable + STB_W'(1);
        end
        r_pwm1 <= r_pwm_sig && (r_stable == STB_MAX) && !w_kill;
        r_pwm2 <= !r_pwm_sig && (r_stable == STB_MAX) && !w_kill;
      end
    end
  end

  assign PWM1_lft     = g_mot[0].r_pwm1;
  assign PWM2_lft     = g_mot[0].r_pwm2;
  assign PWM1_rght    = g_mot[1].r_pwm1;
  assign PWM2_rght    = g_mot[1].r_pwm2;
  assign PWM_synch    = r_synch;
  assign OVR_I_shtdwn = (r_state == ST_SHTDWN);

endmodule

// File: tb/tb_mtr_drv.sv
// Scoreboarded bench for mtr_drv: per-period expected gate high-times and
// shutdown occupancy from a waveform-level model, checked at each PWM_synch.
module tb_mtr_drv;

  localparam int NONOV = 32;
  localparam int BLNK  = 128;
  localparam int LIM   = 4;
  localparam int PER   = 2048;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;
  logic [11:0] lft_spd  = '0;
  logic [11:0] rght_spd = '0;
  logic        OVR_I    = 1'b0;
  logic        PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght, PWM_synch, OVR_I_shtdwn;

  mtr_drv #(.NONOVERLAP(NONOV), .BLANK(BLNK), .OVR_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .lft_spd(lft_spd), .rght_spd(rght_spd), .OVR_I(OVR_I),
    .PWM1_lft(PWM1_lft), .PWM2_lft(PWM2_lft), .PWM1_rght(PWM1_rght),
    .PWM2_rght(PWM2_rght), .PWM_synch(PWM_synch), .OVR_I_shtdwn(OVR_I_shtdwn)
  );

  always #5 clk = ~clk;

  typedef struct { int h1l; int h2l; int h1r; int h2r; int sd; } exp_t;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: speeds, duty of previous/current period, faults
  int lval = 0, rval = 0;
  int dl_prev, dl_cur, dr_prev, dr_cur;
  bit pv, sd;
  int consec;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Gate high-time in a period: the bridge signal over the previous two
  // periods (unknown before reset) must have held one level for NONOV+1 samples.
  function automatic void calc(input int dp, input bit pvalid, input int dc,
                               output int h1, output int h2);
    int s[2*PER];
    for (int i = 0; i < 2*PER; i++) begin
      int k = i % PER;
      int d = (i < PER) ? dp : dc;
      if (i < PER && !pvalid) s[i] = 2;
      else                    s[i] = (k >= 1 && k <= d) ? 1 : 0;
    end
    h1 = 0;
    h2 = 0;
    for (int c = 0; c < PER; c++) begin
      bit all1 = 1'b1;
      bit all0 = 1'b1;
      for (int j = PER + c - 1 - NONOV; j <= PER + c - 1; j++) begin
        if (s[j] != 1) all1 = 1'b0;
        if (s[j] != 0) all0 = 1'b0;
      end
      h1 += int'(all1);
      h2 += int'(all0);
    end
  endfunction

  task automatic model_reset();
    dl_cur = 1024; dr_cur = 1024; dl_prev = 0; dr_prev = 0;
    pv = 1'b0; sd = 1'b0; consec = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_pwm1_lft",  int'(PWM1_lft),     0);
    check("rst_pwm2_lft",  int'(PWM2_lft),     0);
    check("rst_pwm1_rght", int'(PWM1_rght),    0);
    check("rst_pwm2_rght", int'(PWM2_rght),    0);
    check("rst_synch",     int'(PWM_synch),    0);
    check("rst_shtdwn",    int'(OVR_I_shtdwn), 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One full period from cnt 0; OVR_I is driven while oa <= cnt <= ob
  task automatic run_period(input int l_new, input int r_new, input int chg_at,
                            input int oa, input int ob);
    exp_t e;
    if (sd) begin
      e = '{0, 0, 0, 0, PER};
    end else begin
      calc(dl_prev, pv, dl_cur, e.h1l, e.h2l);
      calc(dr_prev, pv, dr_cur, e.h1r, e.h2r);
      e.sd = 0;
    end
    sb.push_back(e);
    for (int c = 0; c < PER; c++) begin
      if (c == chg_at) begin
        lval = l_new; rval = r_new;
        lft_spd = 12'(l_new); rght_spd = 12'(r_new);
      end
      OVR_I = (c >= oa && c <= ob);
      @(posedge clk);
      #1;
    end
    // ovr_s lags OVR_I by two clocks
    if (ob >= oa && ob + 2 >= BLNK) consec++;
    else                            consec = 0;
    if (consec >= LIM) sd = 1'b1;
    dl_prev = dl_cur; dr_prev = dr_cur; pv = 1'b1;
    dl_cur = (lval + 2048) / 2;
    dr_cur = (rval + 2048) / 2;
  endtask

  // Monitor: accumulate per-cycle occupancy, compare at each period end
  initial begin
    int m_len = 0, m_h1l = 0, m_h2l = 0, m_h1r = 0, m_h2r = 0, m_ovl = 0, m_sd = 0;
    int m_per = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_len = 0; m_h1l = 0; m_h2l = 0; m_h1r = 0; m_h2r = 0; m_ovl = 0; m_sd = 0;
      end else begin
        m_len++;
        m_h1l += int'(PWM1_lft);
        m_h2l += int'(PWM2_lft);
        m_h1r += int'(PWM1_rght);
        m_h2r += int'(PWM2_rght);
        m_ovl += int'((PWM1_lft & PWM2_lft) | (PWM1_rght & PWM2_rght));
        m_sd  += int'(OVR_I_shtdwn);
        if (PWM_synch) begin
          m_per++;
          if (sb.size() == 0) begin
            check($sformatf("p%0d_synch_expected", m_per), 0, 1);
          end else begin
            e = sb.pop_front();
            check($sformatf("p%0d_len", m_per),       m_len, PER);
            check($sformatf("p%0d_pwm1_lft", m_per),  m_h1l, e.h1l);
            check($sformatf("p%0d_pwm2_lft", m_per),  m_h2l, e.h2l);
            check($sformatf("p%0d_pwm1_rght", m_per), m_h1r, e.h1r);
            check($sformatf("p%0d_pwm2_rght", m_per), m_h2r, e.h2r);
            check($sformatf("p%0d_overlap", m_per),   m_ovl, 0);
            check($sformatf("p%0d_shtdwn", m_per),    m_sd,  e.sd);
          end
          m_len = 0; m_h1l = 0; m_h2l = 0; m_h1r = 0; m_h2r = 0; m_ovl = 0; m_sd = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #1;
    do_reset();

    // Mid-scale, extremes, mid-period speed change
    run_period(0, 0, -1, 1, 0);
    run_period(0, 0, -1, 1, 0);
    run_period(2047, -2048, 100, 1, 0);
    run_period(2047, -2048, -1, 1, 0);
    run_period(0, 0, 50, 1, 0);
    run_period(1000, 0, 500, 1, 0);
    run_period(1000, 0, -1, 1, 0);

    // Random speeds, change points and overcurrent windows (never enough to trip)
    for (int i = 0; i < 6; i++) begin
      int l, r, ch, mode, a, b;
      l    = int'($urandom_range(0, 4095)) - 2048;
      r    = int'($urandom_range(0, 4095)) - 2048;
      ch   = int'($urandom_range(0, 2046));
      mode = int'($urandom_range(0, 2));
      if (mode == 2 && consec >= LIM - 1) mode = 1;
      if (mode == 0) begin
        a = 1; b = 0;
      end else if (mode == 1) begin
        a = int'($urandom_range(0, BLNK - 3));
        b = int'($urandom_range(a, BLNK - 3));
      end else begin
        a = int'($urandom_range(0, 1900));
        b = int'($urandom_range((a > BLNK - 2) ? a : BLNK - 2, 2000));
      end
      run_period(l, r, ch, a, b);
    end

    // Blanked-only overcurrent, then 3 faulted / 1 clean / 3 faulted.
    // Blanked windows end at BLANK-3 so the delayed ovr_s stays below BLANK.
    run_period(0, 0, 10, 0, BLNK - 3);
    repeat (3) run_period(0, 0, -1, 0, BLNK - 3);
    repeat (3) run_period(0, 0, -1, 200, 300);
    run_period(0, 0, -1, 1, 0);
    repeat (3) run_period(0, 0, -1, 200, 300);
    run_period(0, 0, -1, 0, BLNK - 3);
    check("no_shtdwn_after_3_3", int'(OVR_I_shtdwn), 0);

    // Four consecutive faulted periods trip and latch the shutdown
    repeat (4) run_period(0, 0, -1, 200, 300);
    repeat (2) run_period(0, 0, -1, 1, 0);
    check("shtdwn_latched", int'(OVR_I_shtdwn), 1);

    // Reset mid-period during shutdown, then normal 50% operation
    repeat (700) begin
      @(posedge clk);
      #1;
    end
    do_reset();
    repeat (2) run_period(0, 0, -1, 1, 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
